// File: rtl/divider_pkg.sv
// Types and sizes shared by the divider and its companion multiply-add checker.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    // Scan chain {acc,mcand,mplier,count,state}: 2N + 2N + N + CW + 2 bits.
    localparam int SCAN_LEN = 5 * DATA_W + CNT_W + 2;

endpackage

// File: rtl/multiplier.sv
// Sequential shift-add multiply-add: Product = Operand1*Operand2 + Addend, one multiplier bit
// per clock, with a Req/Done handshake and a full-state scan chain.
module multiplier
    import divider_pkg::*;
#(
    parameter int N  = DATA_W,
    parameter int CW = $clog2(N + 1)
) (
    input  logic           Clock,
    input  logic           nReset,
    input  logic [N-1:0]   Operand1,
    input  logic [N-1:0]   Operand2,
    input  logic [N-1:0]   Addend,
    input  logic           Req,
    input  logic           Test,
    input  logic           SDI,
    output logic           Done,
    output logic           SDO,
    output logic [2*N-1:0] Product
);

    localparam int CHAIN_W = 5 * N + CW + 2;

    logic [2*N-1:0] acc_reg,    acc_next;
    logic [2*N-1:0] mcand_reg,  mcand_next;
    logic [N-1:0]   mplier_reg, mplier_next;
    logic [CW-1:0]  count_reg,  count_next;
    state_t         state_reg,  state_next;

    logic [CHAIN_W-1:0] chain_cur;
    logic [CHAIN_W-1:0] chain_shift;

    assign chain_cur   = {acc_reg, mcand_reg, mplier_reg, count_reg, state_reg};
    assign chain_shift = {SDI, chain_cur[CHAIN_W-1:1]};

    always_comb begin
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        count_next  = count_reg;
        state_next  = state_reg;
        case (state_reg)
            IDLE: begin
                if (Req) begin
                    acc_next    = {{N{1'b0}}, Addend};
                    mcand_next  = {{N{1'b0}}, Operand1};
                    mplier_next = Operand2;
                    count_next  = '0;
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                // Sum is bounded by 2^2N - 2^N, so the 2N-bit add cannot wrap.
                if (mplier_reg[0]) begin
                    acc_next = acc_reg + mcand_reg;
                end
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                count_next  = count_reg + 1'b1;
                if (count_reg == CW'(N - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!Req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            state_reg  <= IDLE;
        end else if (Test) begin
            // Scan freezes the datapath and shifts the whole state one bit toward SDO.
            acc_reg    <= chain_shift[CHAIN_W-1 -: 2*N];
            mcand_reg  <= chain_shift[CHAIN_W-2*N-1 -: 2*N];
            mplier_reg <= chain_shift[N+CW+1 -: N];
            count_reg  <= chain_shift[CW+1 -: CW];
            state_reg  <= state_t'(chain_shift[1:0]);
        end else begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            count_reg  <= count_next;
            state_reg  <= state_next;
        end
    end

    assign Done    = (state_reg == DONE);
    assign SDO     = chain_cur[0];
    assign Product = acc_reg;

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the shift-add multiply-add unit: handshake, arithmetic, reset and scan.
module tb_multiplier;

    logic        Clock;
    logic        nReset;
    logic [7:0]  Operand1;
    logic [7:0]  Operand2;
    logic [7:0]  Addend;
    logic        Req;
    logic        Test;
    logic        SDI;
    logic        Done;
    logic        SDO;
    logic [15:0] Product;

    int n_checks = 0;
    int n_fail   = 0;

    multiplier dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Addend   (Addend),
        .Req      (Req),
        .Test     (Test),
        .SDI      (SDI),
        .Done     (Done),
        .SDO      (SDO),
        .Product  (Product)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Drives operands with Req high and lets the capture edge happen.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        Operand1 = a;
        Operand2 = b;
        Addend   = c;
        Req      = 1'b1;
        step(1);
    endtask

    task automatic test_reset;
        nReset = 1'b0;
        Req = 1'b1; Test = 1'b1; SDI = 1'b1;
        Operand1 = 8'h55; Operand2 = 8'h55; Addend = 8'h55;
        step(2);
        n_checks++;
        if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
        n_checks++;
        if (Product !== 16'h0000) begin n_fail++; $display("FAIL reset_product: got %h want 0000", Product); end
        n_checks++;
        if (SDO !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b want 0", SDO); end
        $display("reset: Done=%b Product=%h SDO=%b", Done, Product, SDO);
        Req = 1'b0; Test = 1'b0; SDI = 1'b0;
        nReset = 1'b1;
        step(1);
    endtask

    task automatic test_basic;
        start_op(8'd3, 8'd3, 8'd0);
        step(7);
        n_checks++;
        if (Done !== 1'b0) begin n_fail++; $display("FAIL basic_early: Done=%b want 0 after 8 edges", Done); end
        step(1);
        n_checks++;
        if (Done !== 1'b1) begin n_fail++; $display("FAIL basic_done: Done=%b want 1 after 9 edges", Done); end
        n_checks++;
        if (Product !== 16'h0009) begin n_fail++; $display("FAIL basic_product: got %h want 0009", Product); end
        $display("op 3*3+0: Done=%b Product=%h", Done, Product);
        // Req still high: the result is held.
        step(2);
        n_checks++;
        if (Done !== 1'b1) begin n_fail++; $display("FAIL basic_hold: Done=%b want 1 while Req high", Done); end
        Req = 1'b0;
        step(1);
        n_checks++;
        if (Done !== 1'b0) begin n_fail++; $display("FAIL basic_release: Done=%b want 0", Done); end
    endtask

    task automatic test_max;
        start_op(8'd255, 8'd255, 8'd255);
        step(8);
        n_checks++;
        if (Done !== 1'b1 || Product !== 16'hFF00) begin
            n_fail++; $display("FAIL max_product: Done=%b Product=%h want 1 FF00", Done, Product);
        end
        $display("op 255*255+255: Done=%b Product=%h", Done, Product);
        Req = 1'b0;
        step(1);
        start_op(8'd0, 8'd200, 8'd17);
        step(8);
        n_checks++;
        if (Done !== 1'b1 || Product !== 16'h0011) begin
            n_fail++; $display("FAIL zero_product: Done=%b Product=%h want 1 0011", Done, Product);
        end
        $display("op 0*200+17: Done=%b Product=%h", Done, Product);
        Req = 1'b0;
        step(1);
    endtask

    task automatic test_pulse;
        start_op(8'd12, 8'd10, 8'd5);
        Req = 1'b0;
        step(7);
        n_checks++;
        if (Done !== 1'b0) begin n_fail++; $display("FAIL pulse_early: Done=%b want 0", Done); end
        step(1);
        n_checks++;
        if (Done !== 1'b1 || Product !== 16'h007D) begin
            n_fail++; $display("FAIL pulse_product: Done=%b Product=%h want 1 007D", Done, Product);
        end
        $display("op 12*10+5 pulsed: Done=%b Product=%h", Done, Product);
        step(1);
        n_checks++;
        if (Done !== 1'b0) begin n_fail++; $display("FAIL pulse_one_cycle: Done=%b want 0", Done); end
    endtask

    task automatic test_reset_mid;
        start_op(8'd9, 8'd9, 8'd9);
        step(3);
        nReset = 1'b0;
        step(1);
        n_checks++;
        if (Done !== 1'b0 || Product !== 16'h0000) begin
            n_fail++; $display("FAIL midreset: Done=%b Product=%h want 0 0000", Done, Product);
        end
        $display("reset mid-op: Done=%b Product=%h", Done, Product);
        nReset = 1'b1;
        Req = 1'b0;
        step(1);
        start_op(8'd7, 8'd6, 8'd0);
        step(8);
        n_checks++;
        if (Done !== 1'b1 || Product !== 16'h002A) begin
            n_fail++; $display("FAIL rerequest: Done=%b Product=%h want 1 002A", Done, Product);
        end
        $display("op 7*6+0: Done=%b Product=%h", Done, Product);
        Req = 1'b0;
        step(1);
    endtask

    task automatic test_operand_change;
        start_op(8'd5, 8'd5, 8'd0);
        Operand1 = 8'hFF; Operand2 = 8'hFF; Addend = 8'hFF;
        step(8);
        n_checks++;
        if (Done !== 1'b1 || Product !== 16'h0019) begin
            n_fail++; $display("FAIL operand_change: Done=%b Product=%h want 1 0019", Done, Product);
        end
        $display("op 5*5+0 with late operand change: Done=%b Product=%h", Done, Product);
        Req = 1'b0;
        step(1);
    endtask

    task automatic test_scan;
        logic [45:0] pat;
        logic [15:0] exp_acc;
        logic        exp_done;
        int          sdo_bad;
        pat      = 46'h25A5_A5A5_A5A5;
        exp_acc  = pat[45:30];
        exp_done = (pat[1:0] == 2'd2);
        Test = 1'b1;
        Req  = 1'b1;
        for (int i = 0; i < 46; i++) begin
            SDI = pat[i];
            step(1);
        end
        n_checks++;
        if (Product !== exp_acc || Done !== exp_done) begin
            n_fail++; $display("FAIL scan_load: Product=%h Done=%b want %h %b", Product, Done, exp_acc, exp_done);
        end
        sdo_bad = 0;
        for (int j = 0; j < 46; j++) begin
            n_checks++;
            if (SDO !== pat[j]) begin
                n_fail++; sdo_bad++;
                $display("FAIL scan_sdo bit %0d: got %b want %b", j, SDO, pat[j]);
            end
            SDI = pat[j];
            step(1);
        end
        n_checks++;
        if (Product !== exp_acc) begin
            n_fail++; $display("FAIL scan_recirc: Product=%h want %h", Product, exp_acc);
        end
        $display("scan 46 bits: Product=%h sdo_errors=%0d", Product, sdo_bad);
        Test = 1'b0; Req = 1'b0; SDI = 1'b0;
        nReset = 1'b0;
        step(1);
        nReset = 1'b1;
    endtask

    initial begin
        nReset = 1'b0; Req = 1'b0; Test = 1'b0; SDI = 1'b0;
        Operand1 = '0; Operand2 = '0; Addend = '0;
        test_reset;
        test_basic;
        test_max;
        test_pulse;
        test_reset_mid;
        test_operand_change;
        test_scan;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
